bloco_operacional: RTL and testbench
====================================

# bloco_operacional

Datapath of the 6-instruction processor, directly downstream of the control unit: it consumes the register-file and ALU control signals and produces the `RF_Rp_zero` status back to the controller. It holds a 16×8-bit register file with two read ports (Rp, Rq) and one write port. It also contains a 3-way write-data mux (ALU / data memory / constant) and an 8-bit ALU. Data memory connects through `D_rdata` (MOVR) and `D_wdata` (MOVD).

## Interface
- `NREG`, default 16: register count; address width fixed at 4 bits.
- `W`, default 8: data width.
- `clk  in  1`: rising-edge clock.
- `reset  in  1`: asynchronous, active-low reset.
- `RF_W_data  in  8`: constant operand (MOVC), from IR[7:0].
- `RF_s1, RF_s0  in  1 each`: write mux select `{s1,s0}`.
- `RF_W_addr  in  4`: write address.
- `RF_W_wr  in  1`: write enable.
- `RF_Rp_addr, RF_Rq_addr  in  4 each`: read addresses.
- `RF_Rp_rd, RF_Rq_rd  in  1 each`: read enables.
- `alu_s1, alu_s0  in  1 each`: ALU op `{s1,s0}`.
- `D_rdata  in  8`: data-memory read data.
- `D_wdata  out  8`: Rp port data to data memory.
- `RF_Rp_zero  out  1`: Rp port data equals zero.

## Operation
- Register file: 16 registers, 8 bits each; the only state in the block.
- Read ports are combinational.
  - `Rp_data = RF_Rp_rd ? R[RF_Rp_addr] : 0`.
  - `Rq_data = RF_Rq_rd ? R[RF_Rq_addr] : 0`.
- ALU `{alu_s1,alu_s0}`:
  - 00: A (Rp_data pass-through)
  - 01: A+B
  - 10: A−B
  - 11: 0
  - A = Rp_data, B = Rq_data.
  - Arithmetic is modulo 2^8; carry and borrow are discarded.
  - 0xFF+0x01 = 0x00; 0x00−0x01 = 0xFF.
- Write mux `{RF_s1,RF_s0}`:
  - 00: ALU result
  - 01: `D_rdata`
  - 10: `RF_W_data`
  - 11: 0x00
- `D_wdata = Rp_data`.
- `RF_Rp_zero = RF_Rp_rd & (Rp_data == 0)`. It is 0 whenever the Rp read is disabled.
- Control-state mapping (informative):
  - CARREGAR: s=01, W_wr.
  - ARMAZENAR: Rp_rd, `D_wdata` valid.
  - SOMAR/SUBTRAIR: Rp_rd, Rq_rd, alu 01/10, s=00, W_wr.
  - CARREGAR_CONST: s=10, W_wr.
  - SALTAR_ZERO: Rp_rd, `RF_Rp_zero` sampled.

## Timing
- Reset asserted (`reset`=0): all registers clear to 0x00 immediately, independent of `clk`.
- Output values during reset with read enables low: `D_wdata`=0x00, `RF_Rp_zero`=0.
- Reset mid-write: reset wins; the register stays 0x00 after reset is released.
- Writes take effect at the rising edge of `clk` when `RF_W_wr`=1 and `reset`=1.
- Read latency is 0 cycles (combinational). A written value is visible on the read ports starting the cycle after the write edge.
- Read and write of the same address in the same cycle: the read returns the old value. The result is deterministic, so a SUB with Ra=Rb is legal.
- `RF_Rp_zero` settles combinationally in the same cycle as `RF_Rp_addr`/`RF_Rp_rd`. This lets the controller branch out of SALTAR_ZERO on the next edge.
- `RF_W_wr`=0: no register changes, whatever the mux select.
- Address 4'hF is valid. There is no out-of-range case.

## Configuration
- Macro: `OPERACIONAL_R0_ZERO_EN`.
  - Defined: R0 is hardwired to 0x00. Writes to address 0 are ignored, and reads of address 0 return 0x00, so `RF_Rp_zero`=1 when Rp_rd=1 and Rp_addr=0. This gives an unconditional JMPZ via R0.
  - Undefined: R0 is an ordinary register.

## Test plan
- Reset: write R3=0x55, assert `reset`=0 between clock edges → R3 reads 0x00 immediately; `D_wdata`=0x00 with rd low.
- MOVC then ADD: R1←0x7F (s=10), R2←0x02, ADD R4=R1+R2 → R4=0x81. Then R5←0xFF, R6←0x01, ADD R7=R5+R6 → R7=0x00.
- SUB wrap and zero flag: R1=0x00, R2=0x01, SUB R3=R1−R2 → R3=0xFF. Then Rp_rd=1, Rp_addr=1 → `RF_Rp_zero`=1. With Rp_rd=0 → `RF_Rp_zero`=0.
- Memory path: `D_rdata`=0xA5, s=01, W_addr=9, W_wr=1 → R9=0xA5 next cycle. Then Rp_addr=9, Rp_rd=1 → `D_wdata`=0xA5.
- Read/write collision: R2=0x10, write R2←0x20 while reading R2 in the same cycle → read shows 0x10; the next cycle shows 0x20.
- With `OPERACIONAL_R0_ZERO_EN` defined: write R0←0x33 → R0 reads 0x00 and `RF_Rp_zero`=1. Without the macro → R0 reads 0x33.

Source files
------------

// File: rtl/bloco_operacional.sv
// Datapath of the 6-instruction processor: 16x8 register file, write-data mux and 8-bit ALU.
// Define OPERACIONAL_R0_ZERO_EN to hardwire R0 to 0x00 (writes to R0 ignored).
module bloco_operacional #(
    parameter int NREG = 16,
    parameter int W    = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] RF_W_data,
    input  logic         RF_s1,
    input  logic         RF_s0,
    input  logic [3:0]   RF_W_addr,
    input  logic         RF_W_wr,
    input  logic [3:0]   RF_Rp_addr,
    input  logic         RF_Rp_rd,
    input  logic [3:0]   RF_Rq_addr,
    input  logic         RF_Rq_rd,
    input  logic         alu_s1,
    input  logic         alu_s0,
    input  logic [W-1:0] D_rdata,
    output logic [W-1:0] D_wdata,
    output logic         RF_Rp_zero
);

    logic [W-1:0] regs_q [NREG];
    logic [W-1:0] regs_d [NREG];
    logic [W-1:0] rp_data;
    logic [W-1:0] rq_data;
    logic [W-1:0] alu_res;
    logic [W-1:0] wr_data;

    function automatic logic [W-1:0] alu_op(input logic [1:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            2'b00:   r = a;
            2'b01:   r = a + b;
            2'b10:   r = a - b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Read ports are purely combinational, so a same-cycle write is seen only after the edge.
    always_comb begin
        rp_data = '0;
        rq_data = '0;
        if (RF_Rp_rd) rp_data = regs_q[RF_Rp_addr];
        if (RF_Rq_rd) rq_data = regs_q[RF_Rq_addr];
    end

    assign alu_res    = alu_op({alu_s1, alu_s0}, rp_data, rq_data);
    assign D_wdata    = rp_data;
    assign RF_Rp_zero = RF_Rp_rd & (rp_data == '0);

    always_comb begin
        case ({RF_s1, RF_s0})
            2'b00:   wr_data = alu_res;
            2'b01:   wr_data = D_rdata;
            2'b10:   wr_data = RF_W_data;
            default: wr_data = '0;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (RF_W_wr) regs_d[RF_W_addr] = wr_data;
`ifdef OPERACIONAL_R0_ZERO_EN
        regs_d[0] = '0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: tb/tb_bloco_operacional.sv
// Directed self-checking bench for bloco_operacional; honours OPERACIONAL_R0_ZERO_EN.
module tb_bloco_operacional;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] RF_W_data;
    logic       RF_s1, RF_s0;
    logic [3:0] RF_W_addr;
    logic       RF_W_wr;
    logic [3:0] RF_Rp_addr, RF_Rq_addr;
    logic       RF_Rp_rd, RF_Rq_rd;
    logic       alu_s1, alu_s0;
    logic [7:0] D_rdata;
    logic [7:0] D_wdata;
    logic       RF_Rp_zero;

    int n_checks = 0;
    int n_fail   = 0;

    bloco_operacional dut (
        .clk       (clk),
        .reset     (reset),
        .RF_W_data (RF_W_data),
        .RF_s1     (RF_s1),
        .RF_s0     (RF_s0),
        .RF_W_addr (RF_W_addr),
        .RF_W_wr   (RF_W_wr),
        .RF_Rp_addr(RF_Rp_addr),
        .RF_Rp_rd  (RF_Rp_rd),
        .RF_Rq_addr(RF_Rq_addr),
        .RF_Rq_rd  (RF_Rq_rd),
        .alu_s1    (alu_s1),
        .alu_s0    (alu_s0),
        .D_rdata   (D_rdata),
        .D_wdata   (D_wdata),
        .RF_Rp_zero(RF_Rp_zero)
    );

    always #5 clk = ~clk;

    // One write cycle: drive after the falling edge, drop the enable just after the rising edge.
    task automatic do_write(input logic [3:0] addr, input logic [1:0] sel, input logic [7:0] k);
        @(negedge clk);
        RF_W_addr = addr;
        {RF_s1, RF_s0} = sel;
        RF_W_data = k;
        RF_W_wr = 1'b1;
        @(posedge clk);
        #1;
        RF_W_wr = 1'b0;
    endtask

    task automatic do_alu(input logic [3:0] dst, input logic [3:0] p, input logic [3:0] q,
                          input logic [1:0] op);
        @(negedge clk);
        RF_Rp_addr = p;
        RF_Rq_addr = q;
        RF_Rp_rd = 1'b1;
        RF_Rq_rd = 1'b1;
        {alu_s1, alu_s0} = op;
        {RF_s1, RF_s0} = 2'b00;
        RF_W_addr = dst;
        RF_W_wr = 1'b1;
        @(posedge clk);
        #1;
        RF_W_wr = 1'b0;
        RF_Rp_rd = 1'b0;
        RF_Rq_rd = 1'b0;
    endtask

    task automatic read_rp(input logic [3:0] addr);
        RF_Rp_addr = addr;
        RF_Rp_rd = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_write(4'd3, 2'b10, 8'h55);
        read_rp(4'd3);
        n_checks++;
        if (D_wdata !== 8'h55) begin
            n_fail++; $display("FAIL reset_pre_R3 got=%h exp=%h", D_wdata, 8'h55);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (D_wdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_async_R3 got=%h exp=%h", D_wdata, 8'h00);
        end
        n_checks++;
        if (RF_Rp_zero !== 1'b1) begin
            n_fail++; $display("FAIL reset_zero_rd got=%b exp=%b", RF_Rp_zero, 1'b1);
        end
        RF_Rp_rd = 1'b0;
        #1;
        n_checks++;
        if (D_wdata !== 8'h00 || RF_Rp_zero !== 1'b0) begin
            n_fail++; $display("FAIL reset_rd_low got=%h/%b exp=00/0", D_wdata, RF_Rp_zero);
        end
        do_write(4'd4, 2'b10, 8'h66);
        @(negedge clk);
        reset = 1'b1;
        read_rp(4'd4);
        n_checks++;
        if (D_wdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_mid_write got=%h exp=%h", D_wdata, 8'h00);
        end
        RF_Rp_rd = 1'b0;
    endtask

    task automatic test_add();
        do_write(4'd1, 2'b10, 8'h7F);
        do_write(4'd2, 2'b10, 8'h02);
        do_alu(4'd4, 4'd1, 4'd2, 2'b01);
        read_rp(4'd4);
        n_checks++;
        if (D_wdata !== 8'h81) begin
            n_fail++; $display("FAIL add_7f_02 got=%h exp=%h", D_wdata, 8'h81);
        end
        do_write(4'd5, 2'b10, 8'hFF);
        do_write(4'd6, 2'b10, 8'h01);
        do_alu(4'd7, 4'd5, 4'd6, 2'b01);
        read_rp(4'd7);
        n_checks++;
        if (D_wdata !== 8'h00 || RF_Rp_zero !== 1'b1) begin
            n_fail++; $display("FAIL add_wrap got=%h/%b exp=00/1", D_wdata, RF_Rp_zero);
        end
        RF_Rp_rd = 1'b0;
    endtask

    task automatic test_sub_zero();
        do_write(4'd1, 2'b10, 8'h00);
        do_write(4'd2, 2'b10, 8'h01);
        do_alu(4'd3, 4'd1, 4'd2, 2'b10);
        read_rp(4'd3);
        n_checks++;
        if (D_wdata !== 8'hFF || RF_Rp_zero !== 1'b0) begin
            n_fail++; $display("FAIL sub_wrap got=%h/%b exp=ff/0", D_wdata, RF_Rp_zero);
        end
        read_rp(4'd1);
        n_checks++;
        if (RF_Rp_zero !== 1'b1) begin
            n_fail++; $display("FAIL zero_flag_rd got=%b exp=%b", RF_Rp_zero, 1'b1);
        end
        RF_Rp_rd = 1'b0;
        #1;
        n_checks++;
        if (RF_Rp_zero !== 1'b0) begin
            n_fail++; $display("FAIL zero_flag_nord got=%b exp=%b", RF_Rp_zero, 1'b0);
        end
        do_alu(4'd8, 4'd3, 4'd2, 2'b00);
        read_rp(4'd8);
        n_checks++;
        if (D_wdata !== 8'hFF) begin
            n_fail++; $display("FAIL alu_pass got=%h exp=%h", D_wdata, 8'hFF);
        end
        do_alu(4'd8, 4'd3, 4'd2, 2'b11);
        read_rp(4'd8);
        n_checks++;
        if (D_wdata !== 8'h00) begin
            n_fail++; $display("FAIL alu_zero_op got=%h exp=%h", D_wdata, 8'h00);
        end
        RF_Rp_rd = 1'b0;
    endtask

    task automatic test_mux_wr();
        do_write(4'd10, 2'b10, 8'h12);
        @(negedge clk);
        RF_W_addr = 4'd10;
        {RF_s1, RF_s0} = 2'b10;
        RF_W_data = 8'h99;
        RF_W_wr = 1'b0;
        @(posedge clk);
        #1;
        read_rp(4'd10);
        n_checks++;
        if (D_wdata !== 8'h12) begin
            n_fail++; $display("FAIL wr_disabled got=%h exp=%h", D_wdata, 8'h12);
        end
        do_write(4'd10, 2'b11, 8'h99);
        read_rp(4'd10);
        n_checks++;
        if (D_wdata !== 8'h00) begin
            n_fail++; $display("FAIL mux_sel11 got=%h exp=%h", D_wdata, 8'h00);
        end
        do_write(4'hF, 2'b10, 8'hF0);
        read_rp(4'hF);
        n_checks++;
        if (D_wdata !== 8'hF0) begin
            n_fail++; $display("FAIL addr_f got=%h exp=%h", D_wdata, 8'hF0);
        end
        RF_Rp_rd = 1'b0;
    endtask

    task automatic test_mem();
        D_rdata = 8'hA5;
        @(negedge clk);
        RF_W_addr = 4'd9;
        {RF_s1, RF_s0} = 2'b01;
        RF_W_wr = 1'b1;
        read_rp(4'd9);
        n_checks++;
        if (D_wdata !== 8'h00) begin
            n_fail++; $display("FAIL mem_before_edge got=%h exp=%h", D_wdata, 8'h00);
        end
        @(posedge clk);
        #1;
        RF_W_wr = 1'b0;
        D_rdata = 8'h3C;
        #1;
        n_checks++;
        if (D_wdata !== 8'hA5) begin
            n_fail++; $display("FAIL mem_movr got=%h exp=%h", D_wdata, 8'hA5);
        end
        RF_Rp_rd = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_write(4'd2, 2'b10, 8'h10);
        @(negedge clk);
        RF_W_addr = 4'd2;
        {RF_s1, RF_s0} = 2'b10;
        RF_W_data = 8'h20;
        RF_W_wr = 1'b1;
        read_rp(4'd2);
        n_checks++;
        if (D_wdata !== 8'h10) begin
            n_fail++; $display("FAIL collide_old got=%h exp=%h", D_wdata, 8'h10);
        end
        @(posedge clk);
        #1;
        RF_W_wr = 1'b0;
        n_checks++;
        if (D_wdata !== 8'h20) begin
            n_fail++; $display("FAIL collide_new got=%h exp=%h", D_wdata, 8'h20);
        end
        do_alu(4'd2, 4'd2, 4'd2, 2'b10);
        read_rp(4'd2);
        n_checks++;
        if (D_wdata !== 8'h00 || RF_Rp_zero !== 1'b1) begin
            n_fail++; $display("FAIL sub_self got=%h/%b exp=00/1", D_wdata, RF_Rp_zero);
        end
        RF_Rp_rd = 1'b0;
    endtask

    task automatic test_r0();
        logic [7:0] exp_v;
        logic       exp_z;
`ifdef OPERACIONAL_R0_ZERO_EN
        exp_v = 8'h00;
        exp_z = 1'b1;
`else
        exp_v = 8'h33;
        exp_z = 1'b0;
`endif
        do_write(4'd0, 2'b10, 8'h33);
        read_rp(4'd0);
        n_checks++;
        if (D_wdata !== exp_v || RF_Rp_zero !== exp_z) begin
            n_fail++; $display("FAIL r0_write got=%h/%b exp=%h/%b", D_wdata, RF_Rp_zero, exp_v, exp_z);
        end
        RF_Rp_rd = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        RF_W_data = '0;
        {RF_s1, RF_s0} = 2'b00;
        RF_W_addr = '0;
        RF_W_wr = 1'b0;
        RF_Rp_addr = '0;
        RF_Rq_addr = '0;
        RF_Rp_rd = 1'b0;
        RF_Rq_rd = 1'b0;
        {alu_s1, alu_s0} = 2'b00;
        D_rdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        test_reset();
        test_add();
        test_sub_zero();
        test_mux_wr();
        test_mem();
        test_back_to_back();
        test_r0();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
